// File: rtl/two_of_five_tx.sv
// Two-out-of-five serial transmitter: accepts one BCD digit per handshake,
// encodes it with 7-4-2-1-0 weighting and shifts the word out MSB first.
// Digits above 9 are flagged on ERR and never transmitted.
module two_of_five_tx #(
   parameter int unsigned BIT_CYCLES = 2,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] DIGIT,
   input  logic       VALID,
   output logic       READY,
   output logic       SDATA,
   output logic       SFRAME,
   output logic [4:0] CODE_OUT,
   output logic       ERR,
   output logic       DONE
);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_e;

   localparam logic [3:0] BitLast = 4'(BIT_CYCLES - 1);
   localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

   state_e     state_q, state_d;
   logic [4:0] shreg_q, shreg_d;
   logic [4:0] code_q, code_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [3:0] cyc_q, cyc_d;
   logic       err_q, err_d;
   logic       done_q, done_d;
   logic [4:0] enc;

   // BCD digit to 7-4-2-1-0 code word; zero uses the 7+4 pair.
   always_comb begin
      enc = 5'b00000;
      unique case (DIGIT)
         4'd0:    enc = 5'b11000;
         4'd1:    enc = 5'b00011;
         4'd2:    enc = 5'b00101;
         4'd3:    enc = 5'b00110;
         4'd4:    enc = 5'b01001;
         4'd5:    enc = 5'b01010;
         4'd6:    enc = 5'b01100;
         4'd7:    enc = 5'b10001;
         4'd8:    enc = 5'b10010;
         4'd9:    enc = 5'b10100;
         default: enc = 5'b00000;
      endcase
   end

   // Next-state logic for the idle / shift / gap sequence.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      code_d    = code_q;
      bit_idx_d = bit_idx_q;
      cyc_d     = cyc_q;
      err_d     = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (VALID) begin
               if (DIGIT <= 4'd9) begin
                  code_d    = enc;
                  shreg_d   = enc;
                  bit_idx_d = 3'd4;
                  cyc_d     = 4'd0;
                  state_d   = StShift;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StShift: begin
            if (cyc_q == BitLast) begin
               cyc_d = 4'd0;
               if (bit_idx_q == 3'd0) begin
                  // Counter restarts at zero so it can time the gap.
                  state_d = StGap;
                  done_d  = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q - 3'd1;
                  shreg_d   = {shreg_q[3:0], 1'b0};
               end
            end else begin
               cyc_d = cyc_q + 4'd1;
            end
         end
         StGap: begin
            if (cyc_q == GapLast) begin
               cyc_d   = 4'd0;
               state_d = StIdle;
            end else begin
               cyc_d = cyc_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; reset abandons any word in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= StIdle;
         shreg_q   <= 5'b00000;
         code_q    <= 5'b00000;
         bit_idx_q <= 3'd0;
         cyc_q     <= 4'd0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         code_q    <= code_d;
         bit_idx_q <= bit_idx_d;
         cyc_q     <= cyc_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   // Outputs decode directly from registers so reset clears them at once.
   assign READY    = (state_q == StIdle);
   assign SFRAME   = (state_q == StShift);
   assign SDATA    = (state_q == StShift) & shreg_q[4];
   assign CODE_OUT = code_q;
   assign ERR      = err_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_two_of_five_tx.sv
// Bench for two_of_five_tx: one instance with BIT_CYCLES=2, one with
// BIT_CYCLES=1; both use GAP_CYCLES=1. Expected words come from a weight
// search over {7,4,2,1,0}, not from a lookup of the RTL table.
module tb_two_of_five_tx;

   logic       clk;
   logic       rst_n;
   logic [3:0] a_digit, b_digit;
   logic       a_valid, b_valid;
   logic       a_ready, a_sdata, a_sframe, a_err, a_done;
   logic       b_ready, b_sdata, b_sframe, b_err, b_done;
   logic [4:0] a_code, b_code;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         sel_q = 0;
   logic [4:0] last_code [2];

   logic       m_ready, m_sdata, m_sframe, m_err, m_done;
   logic [4:0] m_code;

   two_of_five_tx #(.BIT_CYCLES(2), .GAP_CYCLES(1)) dut_a (
      .CLK(clk), .RST_N(rst_n), .DIGIT(a_digit), .VALID(a_valid), .READY(a_ready),
      .SDATA(a_sdata), .SFRAME(a_sframe), .CODE_OUT(a_code), .ERR(a_err), .DONE(a_done)
   );

   two_of_five_tx #(.BIT_CYCLES(1), .GAP_CYCLES(1)) dut_b (
      .CLK(clk), .RST_N(rst_n), .DIGIT(b_digit), .VALID(b_valid), .READY(b_ready),
      .SDATA(b_sdata), .SFRAME(b_sframe), .CODE_OUT(b_code), .ERR(b_err), .DONE(b_done)
   );

   assign m_ready  = (sel_q != 0) ? b_ready  : a_ready;
   assign m_sdata  = (sel_q != 0) ? b_sdata  : a_sdata;
   assign m_sframe = (sel_q != 0) ? b_sframe : a_sframe;
   assign m_err    = (sel_q != 0) ? b_err    : a_err;
   assign m_done   = (sel_q != 0) ? b_done   : a_done;
   assign m_code   = (sel_q != 0) ? b_code   : a_code;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference encoder: pick the two weights summing to the digit (0 -> 11).
   function automatic logic [4:0] model_code(input int d);
      int w [5];
      int target;
      logic [4:0] res;
      w = '{0, 1, 2, 4, 7};
      target = (d == 0) ? 11 : d;
      res = 5'b00000;
      for (int i = 0; i < 5; i++)
         for (int j = i + 1; j < 5; j++)
            if (w[i] + w[j] == target) begin
               res[i] = 1'b1;
               res[j] = 1'b1;
            end
      return res;
   endfunction

   function automatic int popcount5(input logic [4:0] v);
      int n = 0;
      for (int i = 0; i < 5; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [3:0] d);
      if (sel != 0) begin
         b_valid = v;
         b_digit = d;
      end else begin
         a_valid = v;
         a_digit = d;
      end
   endtask

   // Called just after a negedge; returns just after the negedge of the first idle cycle.
   task automatic send(input int sel, input int d, input bit hold, output int acc);
      int bc;
      int n;
      logic [4:0] exp;
      logic [4:0] word;
      bc = (sel != 0) ? 1 : 2;
      sel_q = sel;
      n = 0;
      while (m_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(m_ready), 32'd1);
      exp = model_code(d);
      drive(sel, 1'b1, 4'(d));
      acc = cyc;
      word = 5'b00000;
      for (int k = 0; k < 5 * bc; k++) begin
         @(negedge clk);
         check("sframe", 32'(m_sframe), 32'd1);
         check("sdata", 32'(m_sdata), 32'(exp[4 - k / bc]));
         check("ready_busy", 32'(m_ready), 32'd0);
         check("code_out", 32'(m_code), 32'(exp));
         check("done_early", 32'(m_done), 32'd0);
         if (k % bc == bc - 1) word = {word[3:0], m_sdata};
         if (hold) drive(sel, 1'b1, 4'($urandom_range(0, 15)));
         else drive(sel, 1'b0, 4'd0);
      end
      last_code[sel] = exp;
      check("word", 32'(word), 32'(exp));
      check("two_ones", popcount5(word), 32'd2);
      @(negedge clk);
      check("done", 32'(m_done), 32'd1);
      check("sframe_gap", 32'(m_sframe), 32'd0);
      check("sdata_gap", 32'(m_sdata), 32'd0);
      check("ready_gap", 32'(m_ready), 32'd0);
      @(negedge clk);
      check("ready_idle", 32'(m_ready), 32'd1);
      check("done_once", 32'(m_done), 32'd0);
   endtask

   // Invalid digit on an idle DUT: one ERR pulse, nothing else moves.
   task automatic send_bad(input int sel, input int d);
      sel_q = sel;
      drive(sel, 1'b1, 4'(d));
      @(negedge clk);
      check("err", 32'(m_err), 32'd1);
      check("err_sframe", 32'(m_sframe), 32'd0);
      check("err_ready", 32'(m_ready), 32'd1);
      check("err_code", 32'(m_code), 32'(last_code[sel]));
      drive(sel, 1'b0, 4'd0);
      @(negedge clk);
      check("err_pulse", 32'(m_err), 32'd0);
   endtask

   initial begin
      int acc0, acc1, d;
      rst_n = 1'b0;
      drive(0, 1'b0, 4'd0);
      drive(1, 1'b0, 4'd0);
      last_code[0] = 5'b00000;
      last_code[1] = 5'b00000;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", 32'(a_ready), 32'd1);
      check("rst_sdata", 32'(a_sdata), 32'd0);
      check("rst_sframe", 32'(a_sframe), 32'd0);
      check("rst_code", 32'(a_code), 32'd0);
      check("rst_err", 32'(a_err), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_ready_b", 32'(b_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // First word: digit 4 -> 01001.
      send(0, 4, 1'b0, acc0);
      check("code_4", 32'(a_code), 32'(5'b01001));

      // Sweep all legal digits.
      for (int i = 0; i <= 9; i++) send(0, i, 1'b0, acc0);

      // Invalid digit while the last code is 10100.
      send(0, 9, 1'b0, acc0);
      send_bad(0, 12);
      check("code_hold", 32'(a_code), 32'(5'b10100));

      // Back-to-back invalid accepts give back-to-back ERR pulses.
      sel_q = 0;
      drive(0, 1'b1, 4'd13);
      @(negedge clk);
      check("err_b2b0", 32'(a_err), 32'd1);
      drive(0, 1'b1, 4'd15);
      @(negedge clk);
      check("err_b2b1", 32'(a_err), 32'd1);
      drive(0, 1'b0, 4'd0);
      @(negedge clk);
      check("err_b2b_end", 32'(a_err), 32'd0);

      // VALID held with a churning DIGIT during the word; the next word must
      // start at the first idle cycle.
      send(0, 3, 1'b1, acc0);
      send(0, 6, 1'b0, acc1);
      check("hold_spacing", acc1 - acc0, 32'd12);

      // Random mix of legal and illegal digits.
      for (int i = 0; i < 20; i++) begin
         d = int'($urandom_range(0, 15));
         if (d > 9) send_bad(0, d);
         else send(0, d, 1'b0, acc0);
      end

      // Asynchronous reset during bit 2 of digit 7.
      sel_q = 0;
      drive(0, 1'b1, 4'd7);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(0, 1'b0, 4'd0);
      end
      check("pre_rst_sframe", 32'(a_sframe), 32'd1);
      check("pre_rst_code", 32'(a_code), 32'(5'b10001));
      #1 rst_n = 1'b0;
      #1;
      check("arst_sframe", 32'(a_sframe), 32'd0);
      check("arst_sdata", 32'(a_sdata), 32'd0);
      check("arst_code", 32'(a_code), 32'd0);
      check("arst_ready", 32'(a_ready), 32'd1);
      last_code[0] = 5'b00000;
      last_code[1] = 5'b00000;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_sframe", 32'(a_sframe), 32'd0);
      check("post_rst_ready", 32'(a_ready), 32'd1);
      send(0, 1, 1'b0, acc0);
      check("code_1", 32'(a_code), 32'(5'b00011));

      // Single-cycle bits: 9 then 0 streamed, seven cycles apart.
      send(1, 9, 1'b0, acc0);
      send(1, 0, 1'b0, acc1);
      check("stream_spacing", acc1 - acc0, 32'd7);
      check("code_0_b", 32'(b_code), 32'(5'b11000));
      for (int i = 0; i < 8; i++) send(1, int'($urandom_range(0, 9)), 1'b0, acc0);
      send_bad(1, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/two_of_five_tx.md
Name: two_of_five_tx

Overview:
- Transmit-side counterpart of the two-out-of-five code checker.
- Accepts one BCD digit per transaction over a valid/ready handshake and encodes it into a 5-bit two-out-of-five code word using 7-4-2-1-0 weighting.
- Shifts the code word out serially, MSB first, with a frame strobe, into the link that feeds the checker.
- Flags non-BCD input instead of transmitting it.

Parameters:
- BIT_CYCLES, 2, clock cycles each serial bit is held; legal range 1..15.
- GAP_CYCLES, 1, idle cycles after each word before READY reasserts; legal range 1..15.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DIGIT  input  4  BCD digit to send; sampled on accept.
- VALID  input  1  DIGIT is valid.
- READY  output  1  block can accept a digit.
- SDATA  output  1  serial code bit, MSB (CODE_OUT[4]) first.
- SFRAME  output  1  high while a code bit is being driven on SDATA.
- CODE_OUT  output  5  registered parallel code word of the last valid digit.
- ERR  output  1  one-cycle pulse: the accepted digit was greater than 9.
- DONE  output  1  one-cycle pulse: the last bit of a word has completed.

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect immediately, including mid-word):
  - State goes to IDLE; bit and cycle counters clear.
  - READY=1; SDATA=0; SFRAME=0; CODE_OUT=5'b00000; ERR=0; DONE=0.
  - A word interrupted by reset is abandoned; it is never resumed after reset release.
- Encoding table, CODE[4:0] weights 7,4,2,1,0:
  - 0=11000, 1=00011, 2=00101, 3=00110, 4=01001
  - 5=01010, 6=01100, 7=10001, 8=10010, 9=10100
  - Every output word has exactly two 1s.
- Handshake:
  - Accept occurs on a rising edge where VALID=1 and READY=1.
  - READY is 1 only in IDLE, so READY is low during SHIFT and GAP.
  - DIGIT may change freely when no accept occurs.
- States: IDLE, SHIFT, GAP.
- IDLE, accept with DIGIT<=9:
  - CODE_OUT is loaded with the encoded word; the shift register loads the same word.
  - Bit index resets to 4 and the cycle counter resets to 0; next state is SHIFT.
  - Latency: SFRAME=1 and SDATA=code[4] in the cycle immediately after the accepting edge.
- IDLE, accept with DIGIT>9:
  - ERR=1 for exactly the next cycle.
  - CODE_OUT is unchanged, nothing is transmitted, the state stays IDLE and READY stays 1.
  - Back-to-back invalid accepts produce back-to-back ERR pulses.
- SHIFT:
  - SDATA holds the current bit for BIT_CYCLES cycles, then advances in order 4,3,2,1,0.
  - The frame lasts exactly 5*BIT_CYCLES cycles with SFRAME=1 throughout.
  - After the last cycle of bit 0, go to GAP; DONE=1 in the first GAP cycle.
  - SFRAME=0 and SDATA=0 whenever not in SHIFT.
- GAP:
  - Lasts GAP_CYCLES cycles, then go to IDLE with READY=1.
  - VALID is ignored during SHIFT and GAP.
- Word throughput: one word per 1 + 5*BIT_CYCLES + GAP_CYCLES cycles minimum, counting the accept cycle.
- Counters:
  - Cycle counter is 4 bits wide and wraps to 0 when it reaches BIT_CYCLES-1.
  - Bit index is 3 bits wide and never wraps below 0; the transition to GAP happens at index 0.
- CODE_OUT holds its value until the next valid accept or reset.

Test Plan:
- Reset, then VALID=1 with DIGIT=4, BIT_CYCLES=2 -> CODE_OUT=01001; SDATA over 10 cycles = 0,0,1,1,0,0,0,0,1,1; SFRAME high for 10 cycles; DONE pulses once; READY returns after 1 gap cycle.
- Sweep DIGIT 0..9, each checked serially -> every deserialized word matches the table, contains exactly two 1s, and the checker indicates a valid code.
- DIGIT=12 while CODE_OUT=10100 -> ERR=1 for one cycle; CODE_OUT stays 10100; SFRAME stays 0; READY stays 1.
- VALID held high with DIGIT changing every cycle during SHIFT -> transmitted word unchanged; the next accept occurs only at the first IDLE cycle.
- RST_N pulled low asynchronously during bit 2 of digit 7 -> SFRAME, SDATA and CODE_OUT go to 0 immediately, before the next edge; after release READY=1 and a new DIGIT=1 sends 00011.
- BIT_CYCLES=1, GAP_CYCLES=1, digits 9 then 0 streamed -> accepts spaced 7 cycles apart; SDATA sequence 1,0,1,0,0, gap, 1,1,0,0,0.
